// File: rtl/io_cmd_master.sv
// io_cmd_master: queues I/O register commands in a FIFO and issues them as one-cycle read/write strobes, returning read data
module io_cmd_master #(
  parameter int CMD_DEPTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [31:0]                  cmd_addr,
  input  logic [31:0]                  cmd_wdata,
  output logic [31:0]                  io_addr,
  output logic                         io_write,
  output logic                         io_read,
  output logic [31:0]                  io_wdata,
  input  logic [31:0]                  io_rdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_data,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic                         err_sticky
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(RD_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  state_t state, state_n;
  logic [64:0] mem [CMD_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] cnt;
  logic h_write, cur_write, push, pop, bad, issue, rd_done;
  logic [31:0] h_addr, h_wdata, cur_addr, cur_wdata;
  assign {h_write, h_addr, h_wdata} = mem[rp];
  assign cmd_ready = cmd_count < CW'(CMD_DEPTH);
  assign push = cmd_valid && cmd_ready;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    bad = 1'b0;
    issue = 1'b0;
    rd_done = 1'b0;
    case (state)
      IDLE: begin
        pop = cmd_count != '0;
        bad = pop && h_addr[1:0] != 2'b00;
        state_n = !pop ? IDLE : bad ? (h_write ? IDLE : RESP) : ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        state_n = cur_write ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        rd_done = cnt == LW'(RD_LATENCY);
        state_n = rd_done ? RESP : WAIT_RD;
      end
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {cmd_write, cmd_addr, cmd_wdata};
    if (pop && !bad) {cur_write, cur_addr, cur_wdata} <= {h_write, h_addr, h_wdata};
    cnt <= state == WAIT_RD ? cnt + LW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cmd_count <= '0;
      io_write <= 1'b0;
      io_read <= 1'b0;
      io_addr <= '0;
      io_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      err_sticky <= 1'b0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cmd_count <= cmd_count + CW'(push) - CW'(pop);
      io_write <= issue && cur_write;
      io_read <= issue && !cur_write;
      if (issue) begin
        io_addr <= cur_addr;
        io_wdata <= cur_wdata;
      end
      err_sticky <= err_sticky || bad;
      if (rd_done || (bad && !h_write)) begin
        rsp_valid <= 1'b1;
        rsp_data <= rd_done ? io_rdata : '0;
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_io_cmd_master.sv
// tb_io_cmd_master: scoreboard bench for io_cmd_master covering writes, reads, backpressure, misalignment and reset
module tb_io_cmd_master;
  logic clk, reset, cmd_valid, cmd_ready, cmd_write, io_write, io_read, rsp_valid, rsp_ready, err_sticky;
  logic [31:0] cmd_addr, cmd_wdata, io_addr, io_wdata, io_rdata, rsp_data;
  logic [2:0] cmd_count;
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} strb_t;
  strb_t sq[$];
  logic [31:0] rq[$];
  strb_t e_s;
  logic [31:0] e_r;
  int vectors = 0, miscompares = 0;
  io_cmd_master #(.CMD_DEPTH(4), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .io_addr(io_addr), .io_write(io_write), .io_read(io_read), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cmd_count(cmd_count), .err_sticky(err_sticky)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a == 32'h8 ? 32'h3C : a ^ 32'hC0DE0000;
  endfunction
  always @(posedge clk) if (io_read) io_rdata <= f(io_addr);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (io_write || io_read) begin
      check("strobe_excl", 32'(io_write & io_read), 0);
      check("strobe_pending", 32'(sq.size() != 0), 1);
      if (sq.size() != 0) begin
        e_s = sq.pop_front();
        check("strobe_kind", 32'(io_write), 32'(e_s.w));
        check("strobe_addr", io_addr, e_s.a);
        if (e_s.w) check("strobe_wdata", io_wdata, e_s.d);
      end
    end
    if (rsp_valid && rsp_ready) begin
      check("rsp_pending", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        e_r = rq.pop_front();
        check("rsp_data", rsp_data, e_r);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_rdy, input logic sbs, input logic sbr);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    if (exp_rdy && sbs && a[1:0] == 2'b00) sq.push_back({w, a, d});
    if (exp_rdy && sbr && !w) rq.push_back(a[1:0] != 2'b00 ? 32'h0 : f(a));
    tick();
    cmd_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_count", 32'(cmd_count), 0);
    check("rst_io", {30'd0, io_write, io_read}, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_io_wdata", io_wdata, 0);
    check("rst_rsp", {31'd0, rsp_valid}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", 32'(err_sticky), 0);
    tick();
    reset = 1'b0;
    push(1'b1, 32'h4, 32'hA5, 1'b1, 1'b1, 1'b1);
    @(negedge clk) check("wr_lat_e0", 32'(io_write), 0);
    @(negedge clk) check("wr_lat_e1", 32'(io_write), 0);
    @(negedge clk) check("wr_lat_e2", 32'(io_write), 1);
    check("wr_addr", io_addr, 32'h4);
    check("wr_data", io_wdata, 32'hA5);
    @(negedge clk) check("wr_pulse_end", 32'(io_write), 0);
    check("wr_addr_hold", io_addr, 32'h4);
    check("wr_no_rsp", 32'(rsp_valid), 0);
    repeat (5) tick();
    rsp_ready = 1'b0;
    push(1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check("rd_rsp_arrive", 32'(rsp_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_rsp_hold_v", 32'(rsp_valid), 1);
      check("rd_rsp_hold_d", rsp_data, 32'h3C);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk) check("rd_rsp_clear", 32'(rsp_valid), 0);
    repeat (5) tick();
    push(1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (6) tick();
    check("misalign_err", 32'(err_sticky), 1);
    check("misalign_count", 32'(cmd_count), 0);
    push(1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1);
    push(1'b1, 32'h24, 32'h1111, 1'b1, 1'b1, 1'b1);
    push(1'b0, 32'h28, 32'h0, 1'b1, 1'b1, 1'b1);
    push(1'b1, 32'h2C, 32'h2222, 1'b1, 1'b1, 1'b1);
    push(1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1);
    check("full_count", 32'(cmd_count), 4);
    push(1'b1, 32'h34, 32'h3333, 1'b0, 1'b1, 1'b1);
    check("full_reject_count", 32'(cmd_count), 4);
    repeat (40) tick();
    check("drain_count", 32'(cmd_count), 0);
    check("err_still_set", 32'(err_sticky), 1);
    push(1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 32'h44, 32'h5555, 1'b1, 1'b0, 1'b0);
    push(1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 1'b0);
    check("mid_rd_count", 32'(cmd_count), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_count", 32'(cmd_count), 0);
    check("rst_mid_err", 32'(err_sticky), 0);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 32'(rsp_valid), 0);
    end
    check("sb_strobes_left", sq.size(), 0);
    check("sb_rsps_left", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
